audio_tone_mixer: RTL and testbench

AUDIO_TONE_MIXER -- requirements
Module: audio_tone_mixer

---
 rtl/audio_pkg.sv | 30 +++
 rtl/audio_frame_fifo.sv | 55 +++++
 rtl/audio_tone_mixer.sv | 142 ++++++++++++++
 tb/tb_audio_tone_mixer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types, tone defaults and the saturating adder used by the audio tone mixer.
package audio_pkg;

  localparam int          SAMPLE_W     = 16;
  localparam logic [14:0] TONE_LOW_DEF = 15'd3000;
  localparam int          TONE_AMP_DEF = 10000;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } frame_t;

  // Adds two sign-extended operands and clamps the result to a w-bit signed range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = 33'(a) + 33'(b);
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi)      sum = hi;
    else if (sum < lo) sum = lo;
    return 32'(sum);
  endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Registered-output-free frame FIFO: wrapping pointers, occupancy count, no fall-through.
module audio_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == (AW+1)'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; slots behind a zero count are never read out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/audio_tone_mixer.sv
// Pairs mono/stereo source words into frames, buffers them, and mixes a square tone on output.
module audio_tone_mixer
  import audio_pkg::*;
#(
  parameter int          AUDIO_WIDTH = 16,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [14:0] TONE_LOW    = TONE_LOW_DEF,
  parameter int          TONE_AMP    = TONE_AMP_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic [3:0]             tone_sel,
  input  logic [AUDIO_WIDTH-1:0] src_sample,
  input  logic                   src_wr,
  output logic                   src_ready,
  input  logic                   out_allowed,
  output logic [AUDIO_WIDTH-1:0] out_left,
  output logic [AUDIO_WIDTH-1:0] out_right,
  output logic                   out_write
);

  localparam int W  = AUDIO_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [W:0] L_AMP = (W+1)'(TONE_AMP);

  logic           r_src_ready;
  logic           r_pending;
  logic [W-1:0]   r_held;
  logic           r_mode_d;
  logic [18:0]    r_tone_cnt;
  logic           r_phase;

  logic           w_accept;
  logic           w_mode_chg;
  logic           w_push;
  logic [2*W-1:0] w_wr_frame;
  logic           w_pop;
  logic [2*W-1:0] w_rd_frame;
  logic           w_full;
  logic           w_empty;
  logic [CW-1:0]  w_count;
  logic [CW-1:0]  w_count_next;
  logic [18:0]    w_period;
  logic [18:0]    w_cnt_inc;
  logic signed [W:0] w_tone;
  logic [W-1:0]   w_mix_l;
  logic [W-1:0]   w_mix_r;

  assign src_ready  = r_src_ready;
  assign w_accept   = src_wr && r_src_ready;
  assign w_mode_chg = (mode != r_mode_d);
  assign w_pop      = !w_empty && out_allowed;

  // NOTE: always_comb gives every output a default first, so no path can infer a latch.
  always_comb begin
    w_push     = 1'b0;
    w_wr_frame = {src_sample, src_sample};
    if (w_accept) begin
      if (!mode) begin
        w_push = 1'b1;
      end else if (r_pending && !w_mode_chg) begin
        w_push     = 1'b1;
        w_wr_frame = {r_held, src_sample};
      end
    end
  end

  assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

  audio_frame_fifo #(
    .WIDTH (2*W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push && !w_full),
    .pop     (w_pop),
    .wr_data (w_wr_frame),
    .rd_data (w_rd_frame),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  // A mode flip in either direction drops a held left word; a word arriving then starts fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src_ready <= 1'b0;
      r_pending   <= 1'b0;
      r_held      <= '0;
      r_mode_d    <= 1'b0;
    end else begin
      r_src_ready <= (w_count_next != CW'(FIFO_DEPTH));
      r_mode_d    <= mode;
      if (mode && w_accept) begin
        if (r_pending && !w_mode_chg) begin
          r_pending <= 1'b0;
        end else begin
          r_held    <= src_sample;
          r_pending <= 1'b1;
        end
      end else if (!mode || w_mode_chg) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign w_period  = {tone_sel, TONE_LOW};
  assign w_cnt_inc = r_tone_cnt + 19'd1;
  assign w_tone    = (tone_sel == 4'd0) ? '0 : (r_phase ? L_AMP : -L_AMP);

  always_ff @(posedge clk) begin
    if (reset || tone_sel == 4'd0) begin
      r_tone_cnt <= '0;
      r_phase    <= 1'b0;
    end else if (w_cnt_inc >= w_period) begin
      r_tone_cnt <= '0;
      r_phase    <= ~r_phase;
    end else begin
      r_tone_cnt <= w_cnt_inc;
    end
  end

  assign w_mix_l = W'(sat_add(32'($signed(w_rd_frame[2*W-1:W])), 32'(w_tone), W));
  assign w_mix_r = W'(sat_add(32'($signed(w_rd_frame[W-1:0])), 32'(w_tone), W));

  always_ff @(posedge clk) begin
    if (reset) begin
      out_left  <= '0;
      out_right <= '0;
      out_write <= 1'b0;
    end else begin
      out_write <= w_pop;
      if (w_pop) begin
        out_left  <= w_mix_l;
        out_right <= w_mix_r;
      end
    end
  end

endmodule

// File: tb/tb_audio_tone_mixer.sv
// Directed bench for audio_tone_mixer with an expected-frame queue drained by an output monitor.
module tb_audio_tone_mixer;
  import audio_pkg::*;

  localparam int P = 35768;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b0;
  logic [3:0]  tone_sel = 4'd0;
  logic [15:0] src_sample = '0;
  logic        src_wr = 1'b0;
  logic        src_ready;
  logic        out_allowed = 1'b0;
  logic [15:0] out_left;
  logic [15:0] out_right;
  logic        out_write;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_writes = 0;
  int last_wr_cyc = 0;
  int last_push_cyc = 0;
  int n0 = 0;
  int e1 = 0;
  int e2 = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  audio_tone_mixer dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .tone_sel    (tone_sel),
    .src_sample  (src_sample),
    .src_wr      (src_wr),
    .src_ready   (src_ready),
    .out_allowed (out_allowed),
    .out_left    (out_left),
    .out_right   (out_right),
    .out_write   (out_write)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output strobe is matched against the oldest expected frame.
  always @(negedge clk) begin
    if (out_write) begin
      n_writes++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got %h%h with no frame expected (cycle %0d)",
                 out_left, out_right, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        check("frame", {out_left, out_right}, mon_exp);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_word(input logic [15:0] w);
    int k = 0;
    while (!src_ready && k < 100) begin
      tick();
      k++;
    end
    if (!src_ready) check("ready_timeout", {31'd0, src_ready}, 32'd1);
    src_sample    = w;
    src_wr        = 1'b1;
    last_push_cyc = cyc;
    tick();
    src_wr = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] l, input logic [15:0] r);
    exp_q.push_back({l, r});
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic wait_phase(input logic v);
    int k = 0;
    while (dut.r_phase !== v && k < 40000) begin
      tick();
      k++;
    end
    check("phase_reached", {31'd0, dut.r_phase}, {31'd0, v});
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check("rst_out_left",  {16'd0, out_left}, 32'd0);
    check("rst_out_right", {16'd0, out_right}, 32'd0);
    check("rst_out_write", {31'd0, out_write}, 32'd0);
    check("rst_src_ready", {31'd0, src_ready}, 32'd0);
    check("rst_count",     32'(dut.w_count), 32'd0);
    check("rst_pending",   {31'd0, dut.r_pending}, 32'd0);
    check("rst_tone_cnt",  32'(dut.r_tone_cnt), 32'd0);
    check("rst_phase",     {31'd0, dut.r_phase}, 32'd0);
    reset = 1'b0;
    tick();
    check("ready_after_reset", {31'd0, src_ready}, 32'd1);

    // Mono passthrough and latency
    out_allowed = 1'b1;
    n0 = n_writes;
    push_exp(16'h1234, 16'h1234);
    write_word(16'h1234);
    for (int k = 0; k < 20 && n_writes == n0; k++) tick();
    check("mono_write_seen", n_writes - n0, 32'd1);
    check("mono_latency", last_wr_cyc - last_push_cyc, 32'd2);
    tick();
    check("write_pulse_1cyc", {31'd0, out_write}, 32'd0);

    // Stereo pairing
    mode = 1'b1;
    tick();
    n0 = n_writes;
    push_exp(16'h0100, 16'h0200);
    write_word(16'h0100);
    write_word(16'h0200);
    wait_drain(20);
    tick(2);
    check("stereo_one_write", n_writes - n0, 32'd1);

    // Abandoned half-pair
    n0 = n_writes;
    write_word(16'h0300);
    mode = 1'b0;
    tick();
    mode = 1'b1;
    tick();
    check("pending_cleared", {31'd0, dut.r_pending}, 32'd0);
    tick(5);
    check("abandon_no_write", n_writes - n0, 32'd0);
    push_exp(16'h0400, 16'h0500);
    write_word(16'h0400);
    write_word(16'h0500);
    wait_drain(20);
    mode = 1'b0;
    tick(2);

    // Full and backpressure
    out_allowed = 1'b0;
    n0 = n_writes;
    for (int i = 0; i < 8; i++) begin
      push_exp(16'h1000 + 16'(i), 16'h1000 + 16'(i));
      write_word(16'h1000 + 16'(i));
    end
    check("ready_low_when_full", {31'd0, src_ready}, 32'd0);
    check("count_full", 32'(dut.w_count), 32'd8);
    src_sample = 16'h1FFF;
    src_wr = 1'b1;
    tick();
    src_wr = 1'b0;
    tick();
    check("ninth_ignored", 32'(dut.w_count), 32'd8);
    check("no_write_while_blocked", n_writes - n0, 32'd0);
    out_allowed = 1'b1;
    wait_drain(30);
    tick(2);
    check("full_drain_writes", n_writes - n0, 32'd8);
    check("count_after_drain", 32'(dut.w_count), 32'd0);

    // Reset mid-stream
    out_allowed = 1'b0;
    for (int i = 0; i < 4; i++) write_word(16'h2000 + 16'(i));
    tick();
    check("count_queued", 32'(dut.w_count), 32'd4);
    n0 = n_writes;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_allowed = 1'b1;
    check("reset_flush_count", 32'(dut.w_count), 32'd0);
    check("reset_no_write", {31'd0, out_write}, 32'd0);
    tick();
    check("reset_ready_next", {31'd0, src_ready}, 32'd1);
    check("reset_no_write_after", {31'd0, out_write}, 32'd0);
    tick(5);
    check("reset_no_writes", n_writes - n0, 32'd0);

    // Tone, saturation and half-period
    reset = 1'b1;
    tone_sel = 4'd1;
    tick();
    reset = 1'b0;
    tick();
    push_exp(16'h8000, 16'h8000);
    write_word(16'h8AD0);
    push_exp(16'hEB24, 16'hEB24);
    write_word(16'h1234);
    wait_drain(20);
    wait_phase(1'b1);
    e1 = cyc;
    push_exp(16'h7FFF, 16'h7FFF);
    write_word(16'h7530);
    push_exp(16'h3944, 16'h3944);
    write_word(16'h1234);
    wait_drain(20);
    wait_phase(1'b0);
    e2 = cyc;
    check("tone_half_period", e2 - e1, 32'(P));
    tick(100);
    check("tone_cnt_running", {31'd0, (dut.r_tone_cnt != 19'd0)}, 32'd1);
    tone_sel = 4'd0;
    tick();
    check("tone_off_cnt", 32'(dut.r_tone_cnt), 32'd0);
    check("tone_off_phase", {31'd0, dut.r_phase}, 32'd0);
    check("tone_off_value", 32'(dut.w_tone), 32'd0);
    push_exp(16'h1234, 16'h1234);
    write_word(16'h1234);
    wait_drain(20);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
